// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit-counter width: enough to index WIDTH bits, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_if.sv
// Word handshake and serial output bundle between a parallel producer and piso_tx.
interface piso_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] in;
    logic             in_ready;
    logic             sout;
    logic             sout_valid;
    logic             done;
    logic             busy;

    modport master (
        output in_valid,
        output in,
        input  in_ready,
        input  sout,
        input  sout_valid,
        input  done,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in,
        output in_ready,
        output sout,
        output sout_valid,
        output done,
        output busy
    );
endinterface

// File: rtl/piso_shreg.sv
// Loadable WIDTH-bit shift register; the head bit is the next bit to leave.
module piso_shreg #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic             head
);
    logic [WIDTH-1:0] q;

    // Load has priority over shift; vacated positions fill with zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift_en) begin
            q <= MSB_FIRST ? (q << 1) : (q >> 1);
        end
    end

    assign head = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a word by valid/ready and shifts
// it out one bit per clock, allowing gapless back-to-back words.
module piso_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic   clk,
    input logic   rst,
    piso_if.slave bus
);
    localparam int unsigned CW = cnt_w(WIDTH);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last;
    logic          ready;
    logic          accept;
    logic          head;

    assign last   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    assign ready  = rst && ((state == IDLE) || last);
    assign accept = bus.in_valid && ready;

    // A new word may load on the last-bit edge so consecutive words have no gap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (accept) begin
            state <= SHIFT;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            if (last) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    piso_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .shift_en (state == SHIFT),
        .din      (bus.in),
        .head     (head)
    );

    assign bus.in_ready   = ready;
    assign bus.sout       = (state == SHIFT) && head;
    assign bus.sout_valid = (state == SHIFT);
    assign bus.done       = last;
    assign bus.busy       = (state == SHIFT);

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: three configurations checked against a bit-queue model.
module tb_piso_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    piso_if #(.WIDTH(4)) b0 ();
    piso_if #(.WIDTH(4)) b1 ();
    piso_if #(.WIDTH(1)) b2 ();

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    piso_tx #(.WIDTH(1), .MSB_FIRST(1'b1)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

    int unsigned wd  [3] = '{4, 4, 1};
    bit          msb [3] = '{1'b1, 1'b0, 1'b1};

    // Model: each entry is {bit, last_of_word}; head of queue is on the wire.
    logic [1:0]  mq [3][$];
    logic        iv [3];
    logic [3:0]  iw [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [3:0] cap0, cap1;

    task automatic chk(input string tag, input int d, input logic o, input logic e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s dut%0d cyc%0d got=%b exp=%b", tag, d, cyc, o, e);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] o, input logic [3:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, o, e);
        end
    endtask

    task automatic apply();
        b0.in_valid = iv[0]; b0.in = iw[0];
        b1.in_valid = iv[1]; b1.in = iw[1];
        b2.in_valid = iv[2]; b2.in = iw[2][0];
    endtask

    task automatic idle_all();
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0;
            iw[d] = 4'h0;
        end
        apply();
    endtask

    task automatic offer(input logic v, input logic [3:0] w4, input logic w1);
        iv[0] = v; iw[0] = w4;
        iv[1] = v; iw[1] = w4;
        iv[2] = v; iw[2] = {3'b000, w1};
        apply();
    endtask

    // Check the current cycle against the model, then advance one clock.
    task automatic tick();
        logic os [3], ov [3], od [3], ob [3], orr [3];
        logic rdy [3];
        logic nonempty;
        #1;
        os[0] = b0.sout; ov[0] = b0.sout_valid; od[0] = b0.done; ob[0] = b0.busy; orr[0] = b0.in_ready;
        os[1] = b1.sout; ov[1] = b1.sout_valid; od[1] = b1.done; ob[1] = b1.busy; orr[1] = b1.in_ready;
        os[2] = b2.sout; ov[2] = b2.sout_valid; od[2] = b2.done; ob[2] = b2.busy; orr[2] = b2.in_ready;
        if (b0.sout_valid) cap0 = {cap0[2:0], b0.sout};
        if (b1.sout_valid) cap1 = {cap1[2:0], b1.sout};
        for (int d = 0; d < 3; d++) begin
            nonempty = (mq[d].size() > 0);
            rdy[d]   = rst && (mq[d].size() <= 1);
            chk("sout",       d, os[d],  nonempty ? mq[d][0][1] : 1'b0);
            chk("sout_valid", d, ov[d],  nonempty);
            chk("done",       d, od[d],  nonempty ? mq[d][0][0] : 1'b0);
            chk("busy",       d, ob[d],  nonempty);
            chk("in_ready",   d, orr[d], rdy[d]);
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (!rst) begin
                mq[d].delete();
            end else begin
                if (mq[d].size() > 0) void'(mq[d].pop_front());
                if (iv[d] && rdy[d]) begin
                    for (int k = 0; k < int'(wd[d]); k++) begin
                        int idx;
                        idx = msb[d] ? int'(wd[d]) - 1 - k : k;
                        mq[d].push_back({iw[d][idx], (k == int'(wd[d]) - 1)});
                    end
                end
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        idle_all();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        // Single word 1011; WIDTH=1 unit sends a 1.
        cap0 = '0; cap1 = '0;
        offer(1'b1, 4'b1011, 1'b1);
        tick();
        idle_all();
        repeat (5) tick();
        chk4("single_msb", cap0, 4'b1011);
        chk4("single_lsb", cap1, 4'b1101);

        // Back-to-back words with in_valid held high.
        cap0 = '0;
        offer(1'b1, 4'b1011, 1'b1);
        tick();
        offer(1'b1, 4'b0110, 1'b0);
        repeat (4) tick();
        chk4("b2b_first", cap0, 4'b1011);
        idle_all();
        repeat (5) tick();
        chk4("b2b_second", cap0, 4'b0110);

        // Offer held during a word is ignored until the last-bit cycle.
        offer(1'b1, 4'b1011, 1'b1);
        tick();
        offer(1'b1, 4'b1111, 1'b0);
        repeat (4) tick();
        idle_all();
        repeat (5) tick();

        // Reset mid-word after bit 2.
        offer(1'b1, 4'b1011, 1'b1);
        tick();
        idle_all();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (3) tick();

        // Reset on the same edge as a handshake: reset wins.
        offer(1'b1, 4'b1001, 1'b1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        idle_all();
        repeat (2) tick();

        // WIDTH=1 stream 1,0,1 on consecutive edges.
        offer(1'b1, 4'b0000, 1'b1);
        tick();
        offer(1'b1, 4'b0000, 1'b0);
        tick();
        offer(1'b1, 4'b0000, 1'b1);
        tick();
        idle_all();
        repeat (5) tick();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) != 0);
            for (int d = 0; d < 3; d++) begin
                iv[d] = ($urandom_range(0, 3) != 0);
                iw[d] = 4'($urandom);
            end
            apply();
            tick();
        end
        rst = 1'b1;
        idle_all();
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in serial-out transmitter. It is the serial-producing counterpart of the team's parallel register blocks. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, with a qualifying valid strobe and an end-of-word pulse. It sits between a parallel producer (register file, PIPO stage) and a serial link or SIPO receiver. It supports gapless back-to-back words.

## Interface
- WIDTH, 4: word width in bits; legal values are 1 and above.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  producer has a word on `in`.
- in  input  WIDTH  parallel word to transmit.
- in_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a valid bit this cycle.
- done  output  1  one-cycle pulse coincident with the last bit of a word.
- busy  output  1  a word is in flight (state is SHIFT).

## Operation
- The FSM has two states: IDLE and SHIFT. Reset state is IDLE.
- A transfer is accepted on an edge where in_valid=1 and in_ready=1. The word is captured into the shift register, the bit counter is set to 0, and the state goes to SHIFT.
- In SHIFT:
  - sout is the current head bit of the shift register. The head is `in[WIDTH-1]` when MSB_FIRST=1, `in[0]` otherwise.
  - sout_valid=1.
  - Each edge shifts by one bit and increments the counter.
- The last bit is reached when counter == WIDTH-1. In that cycle:
  - done=1.
  - in_ready=1.
  - If a transfer is accepted on that edge, the new word loads and SHIFT continues with counter=0.
  - Otherwise the state returns to IDLE.
- in_ready = (state==IDLE) or (state==SHIFT and last bit). in_ready is forced to 0 while rst=0.
- in_valid in any non-last SHIFT cycle is ignored. The producer must hold its word until in_ready. Neither the shift register nor the counter is disturbed.
- Counter width is $clog2(WIDTH), with a minimum of 1. The counter never exceeds WIDTH-1; no wrap-around beyond the word.
- Vacated shift-register positions fill with 0.
- In IDLE: sout=0, sout_valid=0, done=0, busy=0.
- Reset values after a clock edge with rst=0:
  - state IDLE
  - shift register 0, counter 0
  - sout 0, sout_valid 0, done 0, busy 0
  - in_ready 1 once rst returns to 1
- Reset mid-word aborts the word. Remaining bits are discarded and never emitted.
- If reset is asserted on the same edge as a handshake, reset wins and the word is not accepted.

## Timing
- Latency: a word accepted at edge N drives its first bit on sout in cycle N+1. It drives its last bit in cycle N+WIDTH.
- Throughput is one bit per clock. Back-to-back words produce exactly WIDTH×k contiguous sout_valid cycles.
- The register-to-output path is direct: sout, sout_valid, done and busy are decoded from registered state and the register head only.
- in_ready is combinational from state, counter and rst. It has no path from in_valid.
- WIDTH=1:
  - Every SHIFT cycle is a last-bit cycle, so done=1 and in_ready=1 throughout SHIFT.
  - A continuous in_valid gives one word per clock.

## Structure
- Shared package `piso_pkg` holds:
  - the state typedef (IDLE, SHIFT)
  - the counter-width function/constant derived from WIDTH
- The natural sub-module is `piso_shreg`, a WIDTH-bit loadable shift register. It has a load and shift enable, a direction set by MSB_FIRST, and synchronous active-low clear.
- The top level `piso_tx` holds the FSM, the counter and the handshake decode.

## Test plan
- Single word: WIDTH=4, MSB_FIRST=1, load 4'b1011 at edge 0.
  - sout = 1,0,1,1 in cycles 1–4 with sout_valid=1.
  - done=1 only in cycle 4.
  - In cycle 5: sout_valid=0 and in_ready=1.
- Back-to-back: 4'b1011, then 4'b0110 offered with in_valid held high.
  - Second word is accepted at the cycle-4 edge.
  - sout = 1,0,1,1,0,1,1,0 over cycles 1–8 with no gap; done in cycles 4 and 8.
- Ignored offer: in_valid=1 with in=4'b1111 during cycles 1–3 of word 4'b1011.
  - in_ready=0 in cycles 1–3.
  - Output stream remains 1,0,1,1.
  - 4'b1111 is accepted only at the cycle-4 edge.
- Reset mid-word: drive rst=0 at the edge after bit 2 of 4'b1011.
  - Next cycle: sout=0, sout_valid=0, busy=0.
  - Bits 3–4 are never emitted; in_ready=1 after rst=1.
- LSB-first: MSB_FIRST=0, load 4'b1011 → sout = 1,1,0,1 in cycles 1–4.
- WIDTH=1: continuous in_valid with in = 1,0,1 → sout = 1,0,1 in cycles 1–3, with done=1 and in_ready=1 each cycle.
